// File: rtl/interleaver_pkg.sv
// Shared types and helpers for the WiMAX OFDM bit interleaver/deinterleaver.
package interleaver_pkg;

  localparam int NCBPS_BASE_DEF = 192;
  localparam int D_COLS         = 16;
  localparam int NCBPS_MAX_DEF  = 576;

  typedef enum logic [1:0] {
    MODE_QPSK  = 2'b00,
    MODE_16QAM = 2'b01,
    MODE_64QAM = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'b00,
    BANK_FILLING  = 2'b01,
    BANK_FULL     = 2'b10,
    BANK_DRAINING = 2'b11
  } bank_state_t;

  // Raw mode code to enum; the reserved code 11 falls back to QPSK.
  function automatic mode_t to_mode(logic [1:0] code);
    case (code)
      2'b01:   return MODE_16QAM;
      2'b10:   return MODE_64QAM;
      default: return MODE_QPSK;
    endcase
  endfunction

  // Coded bits per subcarrier.
  function automatic logic [2:0] ncpc_of(mode_t m);
    case (m)
      MODE_16QAM: return 3'd4;
      MODE_64QAM: return 3'd6;
      default:    return 3'd2;
    endcase
  endfunction

  // Coded bits per OFDM block for a given QPSK base size.
  function automatic int ncbps_of(mode_t m, int base);
    return (base * int'(ncpc_of(m))) / 32'sd2;
  endfunction

endpackage

// File: rtl/interleaver_perm.sv
// Combinational two-step 802.16 interleaver permutation: input index k -> output index j.
module interleaver_perm
  import interleaver_pkg::*;
#(
  parameter int NCBPS_BASE = NCBPS_BASE_DEF,
  parameter int D          = D_COLS,
  parameter int ADDR_W     = 10
) (
  input  logic [ADDR_W-1:0] k,
  input  mode_t             mode,
  output logic [ADDR_W-1:0] j
);

  // Wide intermediates so D*m never overflows before the final reduction.
  localparam int W = ADDR_W + 5;

  logic [W-1:0] n_s;
  logic [W-1:0] s_s;
  logic [W-1:0] m_s;
  logic [W-1:0] t_s;

  // First step spreads adjacent bits over columns, second rotates within s-groups.
  always_comb begin
    n_s = W'(ncbps_of(mode, NCBPS_BASE));
    s_s = W'(ncpc_of(mode) / 3'd2);
    m_s = (n_s / W'(D)) * (W'(k) % W'(D)) + (W'(k) / W'(D));
    t_s = (m_s + n_s - ((W'(D) * m_s) / n_s)) % s_s;
    j   = ADDR_W'(s_s * (m_s / s_s) + t_s);
  end

endmodule

// File: rtl/interleaver_pp.sv
// Ping-pong bit interleaver: one bank fills in natural order while the other drains.
module interleaver_pp
  import interleaver_pkg::*;
#(
  parameter int NCBPS_BASE = NCBPS_BASE_DEF,
  parameter int D          = D_COLS,
  parameter int NCBPS_MAX  = NCBPS_MAX_DEF,
  parameter int ADDR_W     = $clog2(NCBPS_MAX)
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [1:0]        mode,
  input  logic              valid_fec,
  input  logic              data_in,
  output logic              ready_interleaver,
  input  logic              ready_mod,
  output logic              valid_interleaver,
  output logic              data_out,
  output logic [ADDR_W-1:0] data_out_index,
  output logic              block_last,
  output logic [1:0]        block_mode
);

  logic [NCBPS_MAX-1:0] mem_r [2];
  bank_state_t          st_r [2];
  mode_t                bmode_r [2];
  logic                 wr_bank_r;
  logic                 rd_bank_r;
  logic [ADDR_W-1:0]    k_r;
  logic [ADDR_W-1:0]    rd_ptr_r;

  logic                 ready_r;
  logic                 valid_r;
  logic                 dout_r;
  logic [ADDR_W-1:0]    idx_r;
  logic                 last_r;
  mode_t                omode_r;

  mode_t                wmode_s;
  logic [ADDR_W-1:0]    wlast_s;
  logic [ADDR_W-1:0]    waddr_s;
  logic                 in_hs_s;
  logic                 wr_done_s;
  logic                 wr_bank_nxt_s;
  logic [ADDR_W-1:0]    k_nxt_s;
  logic                 out_hs_s;
  logic                 rd_bank_nxt_s;
  logic [ADDR_W-1:0]    rd_ptr_nxt_s;
  logic                 valid_nxt_s;
  logic                 load_s;
  mode_t                rmode_s;
  logic [ADDR_W-1:0]    rlast_s;
  bank_state_t          st_nxt_s [2];
  logic                 ready_nxt_s;

  interleaver_perm #(
    .NCBPS_BASE(NCBPS_BASE),
    .D         (D),
    .ADDR_W    (ADDR_W)
  ) u_perm (
    .k   (k_r),
    .mode(wmode_s),
    .j   (waddr_s)
  );

  // Write side: the first bit of a block uses the live mode, later bits the latched one.
  always_comb begin
    wmode_s       = (k_r == {ADDR_W{1'b0}}) ? to_mode(mode) : bmode_r[wr_bank_r];
    wlast_s       = ADDR_W'(ncbps_of(wmode_s, NCBPS_BASE) - 1);
    in_hs_s       = valid_fec & ready_r;
    wr_done_s     = in_hs_s & (k_r == wlast_s);
    wr_bank_nxt_s = wr_done_s ? ~wr_bank_r : wr_bank_r;
    k_nxt_s       = wr_done_s ? {ADDR_W{1'b0}} : (in_hs_s ? k_r + ADDR_W'(1) : k_r);
  end

  // Read side: reload the output stage on a handshake or whenever it holds nothing.
  always_comb begin
    out_hs_s      = valid_r & ready_mod;
    rd_bank_nxt_s = rd_bank_r;
    rd_ptr_nxt_s  = rd_ptr_r;
    valid_nxt_s   = valid_r;
    load_s        = 1'b0;
    if (out_hs_s) begin
      load_s = 1'b1;
      if (last_r) begin
        rd_bank_nxt_s = ~rd_bank_r;
        rd_ptr_nxt_s  = {ADDR_W{1'b0}};
        valid_nxt_s   = (st_r[~rd_bank_r] == BANK_FULL);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r + ADDR_W'(1);
        valid_nxt_s  = 1'b1;
      end
    end else if (!valid_r) begin
      load_s      = 1'b1;
      valid_nxt_s = (st_r[rd_bank_r] == BANK_FULL);
    end else begin
      load_s = 1'b0;
    end
    rmode_s = bmode_r[rd_bank_nxt_s];
    rlast_s = ADDR_W'(ncbps_of(rmode_s, NCBPS_BASE) - 1);
  end

  // Bank state updates; write and read never touch the same bank in one cycle.
  always_comb begin
    st_nxt_s[0] = st_r[0];
    st_nxt_s[1] = st_r[1];
    if (in_hs_s) begin
      st_nxt_s[wr_bank_r] = wr_done_s ? BANK_FULL : BANK_FILLING;
    end else begin
      st_nxt_s[wr_bank_r] = st_r[wr_bank_r];
    end
    if (out_hs_s && last_r) begin
      st_nxt_s[rd_bank_r] = BANK_EMPTY;
    end else begin
      st_nxt_s[rd_bank_r] = st_nxt_s[rd_bank_r];
    end
    if (load_s && valid_nxt_s) begin
      st_nxt_s[rd_bank_nxt_s] = BANK_DRAINING;
    end else begin
      st_nxt_s[rd_bank_nxt_s] = st_nxt_s[rd_bank_nxt_s];
    end
    ready_nxt_s = (st_nxt_s[wr_bank_nxt_s] == BANK_EMPTY) ||
                  (st_nxt_s[wr_bank_nxt_s] == BANK_FILLING);
  end

  // Bank bookkeeping, pointers and the latched per-bank mode.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      st_r[0]    <= BANK_EMPTY;
      st_r[1]    <= BANK_EMPTY;
      bmode_r[0] <= MODE_QPSK;
      bmode_r[1] <= MODE_QPSK;
      wr_bank_r  <= 1'b0;
      rd_bank_r  <= 1'b0;
      k_r        <= {ADDR_W{1'b0}};
      rd_ptr_r   <= {ADDR_W{1'b0}};
    end else begin
      st_r[0]   <= st_nxt_s[0];
      st_r[1]   <= st_nxt_s[1];
      if (in_hs_s && (k_r == {ADDR_W{1'b0}})) begin
        bmode_r[wr_bank_r] <= wmode_s;
      end
      wr_bank_r <= wr_bank_nxt_s;
      rd_bank_r <= rd_bank_nxt_s;
      k_r       <= k_nxt_s;
      rd_ptr_r  <= rd_ptr_nxt_s;
    end
  end

  // Bit storage: scatter each incoming bit to its permuted position.
  always_ff @(posedge clk) begin
    if (in_hs_s) begin
      mem_r[wr_bank_r][waddr_s] <= data_in;
    end
  end

  // Registered handshake and output stage; holds steady while the modulator stalls.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      ready_r <= 1'b0;
      valid_r <= 1'b0;
      dout_r  <= 1'b0;
      idx_r   <= {ADDR_W{1'b0}};
      last_r  <= 1'b0;
      omode_r <= MODE_QPSK;
    end else begin
      ready_r <= ready_nxt_s;
      if (load_s) begin
        valid_r <= valid_nxt_s;
        idx_r   <= rd_ptr_nxt_s;
        if (valid_nxt_s) begin
          dout_r  <= mem_r[rd_bank_nxt_s][rd_ptr_nxt_s];
          last_r  <= (rd_ptr_nxt_s == rlast_s);
          omode_r <= rmode_s;
        end else begin
          dout_r <= 1'b0;
          last_r <= 1'b0;
        end
      end
    end
  end

  assign ready_interleaver = ready_r;
  assign valid_interleaver = valid_r;
  assign data_out          = dout_r;
  assign data_out_index    = idx_r;
  assign block_last        = last_r;
  assign block_mode        = omode_r;

endmodule

// File: tb/tb_interleaver_pp.sv
// Scoreboard bench for interleaver_pp: expected bits are queued as blocks are driven.
module tb_interleaver_pp;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          valid_fec = 1'b0;
  logic          data_in = 1'b0;
  logic          ready_interleaver;
  logic          ready_mod = 1'b0;
  logic          valid_interleaver;
  logic          data_out;
  logic [AW-1:0] data_out_index;
  logic          block_last;
  logic [1:0]    block_mode;

  typedef struct packed {
    logic          d;
    logic [AW-1:0] idx;
    logic          last;
    logic [1:0]    m;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   ones_cnt = 0;
  int   one_idx = -1;
  int   last_idx = -1;
  int   out_cnt = 0;
  int   stall_cnt = 0;
  bit   blk[576];

  interleaver_pp dut (
    .clk              (clk),
    .resetN           (resetN),
    .mode             (mode),
    .valid_fec        (valid_fec),
    .data_in          (data_in),
    .ready_interleaver(ready_interleaver),
    .ready_mod        (ready_mod),
    .valid_interleaver(valid_interleaver),
    .data_out         (data_out),
    .data_out_index   (data_out_index),
    .block_last       (block_last),
    .block_mode       (block_mode)
  );

  always #5 clk = ~clk;

  function automatic int ncpc_tb(logic [1:0] m);
    return (m == 2'b01) ? 4 : ((m == 2'b10) ? 6 : 2);
  endfunction

  // Reference permutation straight from the standard's formula.
  function automatic int perm_j(int k, int ncpc);
    int n, s, m;
    n = 96 * ncpc;
    s = ncpc / 2;
    m = (n / 16) * (k % 16) + k / 16;
    return s * (m / s) + ((m + n - (16 * m) / n) % s);
  endfunction

  // Output monitor: compare every output handshake against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (resetN && valid_interleaver && ready_mod) begin
      n_tests++;
      out_cnt++;
      if (data_out) begin ones_cnt++; one_idx = int'(data_out_index); end
      if (block_last) last_idx = int'(data_out_index);
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output idx=%0d (no bit expected)", data_out_index);
      end else begin
        e = sb.pop_front();
        if ({data_out, data_out_index, block_last, block_mode} !== {e.d, e.idx, e.last, e.m}) begin
          n_fail++;
          $display("FAIL out_bit got d=%0b idx=%0d last=%0b mode=%0d required d=%0b idx=%0d last=%0b mode=%0d",
                   data_out, data_out_index, block_last, block_mode, e.d, e.idx, e.last, e.m);
        end
      end
    end
  end

  task automatic set_single(input int k);
    for (int i = 0; i < 576; i++) blk[i] = 1'b0;
    blk[k] = 1'b1;
  endtask

  task automatic set_random();
    for (int i = 0; i < 576; i++) blk[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic push_expected(input logic [1:0] m);
    bit   o[576];
    exp_t e;
    int   ncpc, n;
    logic [1:0] mm;
    mm   = (m == 2'b11) ? 2'b00 : m;
    ncpc = ncpc_tb(mm);
    n    = 96 * ncpc;
    for (int k = 0; k < n; k++) o[perm_j(k, ncpc)] = blk[k];
    for (int j = 0; j < n; j++) begin
      e.d = o[j]; e.idx = AW'(j); e.last = (j == n - 1); e.m = mm;
      sb.push_back(e);
    end
  endtask

  task automatic drive_bit(input logic [1:0] m, input bit b);
    int guard = 0;
    mode = m; data_in = b; valid_fec = 1'b1;
    @(negedge clk);
    while (!ready_interleaver && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    stall_cnt += guard;
    if (!ready_interleaver) begin
      n_tests++; n_fail++;
      $display("FAIL input_timeout ready_interleaver=0 required 1 within 2000 cycles");
    end
    @(posedge clk); #1;
    valid_fec = 1'b0;
  endtask

  // Sends blk[0..n-1]; with scramble the mode pins change after the first bit.
  task automatic send_block(input logic [1:0] m, input bit scramble);
    int n;
    n = 96 * ncpc_tb(m);
    for (int k = 0; k < n; k++) drive_bit((scramble && k != 0) ? 2'b01 : m, blk[k]);
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((sb.size() != 0 || valid_interleaver) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain remaining=%0d required 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic single_run(input logic [1:0] m, input int k, input int exp_idx, input bit scramble);
    ones_cnt = 0; one_idx = -1; last_idx = -1;
    set_single(k);
    push_expected(m);
    send_block(m, scramble);
    wait_drain();
    n_tests++;
    if (ones_cnt !== 1 || one_idx !== exp_idx) begin
      n_fail++;
      $display("FAIL single_one mode=%0d k=%0d got count=%0d idx=%0d required count=1 idx=%0d",
               m, k, ones_cnt, one_idx, exp_idx);
    end
    n_tests++;
    if (last_idx !== 96 * ncpc_tb(m) - 1) begin
      n_fail++;
      $display("FAIL block_last mode=%0d got idx=%0d required %0d", m, last_idx, 96 * ncpc_tb(m) - 1);
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({valid_interleaver, ready_interleaver} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_hs got valid=%0b ready=%0b required 0 0", valid_interleaver, ready_interleaver);
    end
    n_tests++;
    if ({data_out, data_out_index, block_last, block_mode} !== '0) begin
      n_fail++;
      $display("FAIL reset_out got d=%0b idx=%0d last=%0b mode=%0d required all 0",
               data_out, data_out_index, block_last, block_mode);
    end
    resetN = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (ready_interleaver !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release ready=%0b required 1", ready_interleaver);
    end
  endtask

  task automatic test_qpsk();
    ready_mod = 1'b1;
    ones_cnt = 0; one_idx = -1; last_idx = -1;
    set_single(1);
    push_expected(2'b00);
    send_block(2'b00, 1'b0);
    n_tests++;
    if (valid_interleaver !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early valid=%0b required 0 one cycle after last input", valid_interleaver);
    end
    @(posedge clk); #1;
    n_tests++;
    if (valid_interleaver !== 1'b1) begin
      n_fail++;
      $display("FAIL latency valid=%0b required 1 two cycles after last input", valid_interleaver);
    end
    wait_drain();
    n_tests++;
    if (ones_cnt !== 1 || one_idx !== 12 || last_idx !== 191) begin
      n_fail++;
      $display("FAIL qpsk_k1 got count=%0d idx=%0d last=%0d required 1 12 191", ones_cnt, one_idx, last_idx);
    end
    single_run(2'b00, 16, 1, 1'b0);
  endtask

  task automatic test_16qam();
    ready_mod = 1'b1;
    single_run(2'b01, 1, 25, 1'b0);
    single_run(2'b01, 0, 0, 1'b0);
  endtask

  task automatic test_64qam();
    ready_mod = 1'b1;
    single_run(2'b10, 1, 38, 1'b1);
  endtask

  task automatic test_back_to_back();
    ready_mod = 1'b1;
    stall_cnt = 0;
    set_random();
    push_expected(2'b00);
    send_block(2'b00, 1'b0);
    set_random();
    push_expected(2'b10);
    send_block(2'b10, 1'b0);
    n_tests++;
    if (stall_cnt !== 0) begin
      n_fail++;
      $display("FAIL b2b_stall got %0d stall cycles required 0", stall_cnt);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic          hold_d;
    logic [AW-1:0] hold_i;
    ready_mod = 1'b0;
    stall_cnt = 0;
    out_cnt = 0;
    set_random();
    push_expected(2'b00);
    send_block(2'b00, 1'b0);
    set_random();
    push_expected(2'b00);
    send_block(2'b00, 1'b0);
    n_tests++;
    if (ready_interleaver !== 1'b0 || stall_cnt !== 0) begin
      n_fail++;
      $display("FAIL bp_ready got ready=%0b stalls=%0d required 0 0", ready_interleaver, stall_cnt);
    end
    @(negedge clk);
    hold_d = data_out;
    hold_i = data_out_index;
    n_tests++;
    if (valid_interleaver !== 1'b1 || hold_i !== 0 || hold_d !== sb[0].d) begin
      n_fail++;
      $display("FAIL bp_head got valid=%0b idx=%0d d=%0b required 1 0 %0b",
               valid_interleaver, hold_i, hold_d, sb[0].d);
    end
    repeat (15) begin
      @(negedge clk);
      n_tests++;
      if (data_out !== hold_d || data_out_index !== hold_i || block_last !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold got d=%0b idx=%0d last=%0b required %0b %0d 0",
                 data_out, data_out_index, block_last, hold_d, hold_i);
      end
    end
    @(posedge clk); #1;
    ready_mod = 1'b1;
    wait_drain();
    n_tests++;
    if (out_cnt !== 384) begin
      n_fail++;
      $display("FAIL bp_count got %0d bits required 384", out_cnt);
    end
  endtask

  task automatic test_reset_mid();
    ready_mod = 1'b1;
    set_random();
    for (int k = 0; k < 100; k++) drive_bit(2'b00, blk[k]);
    resetN = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({valid_interleaver, ready_interleaver} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_fill got valid=%0b ready=%0b required 0 0", valid_interleaver, ready_interleaver);
    end
    resetN = 1'b1;
    @(posedge clk); #1;
    set_random();
    push_expected(2'b10);
    send_block(2'b10, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    ready_mod = 1'b0;
    resetN = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({valid_interleaver, ready_interleaver} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_drain got valid=%0b ready=%0b required 0 0", valid_interleaver, ready_interleaver);
    end
    sb.delete();
    resetN = 1'b1;
    @(posedge clk); #1;
    ready_mod = 1'b1;
    single_run(2'b00, 1, 12, 1'b0);
  endtask

  initial begin
    test_reset();
    test_qpsk();
    test_16qam();
    test_64qam();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/interleaver_pp.md
Name: interleaver_pp

Overview:
Parametrised, multi-mode WiMAX OFDM bit interleaver sitting between the FEC encoder and the modulator mapper. It implements the IEEE 802.16 two-step permutation for QPSK, 16-QAM and 64-QAM, with the mode selected per block. Two ping-pong bit banks allow one block to fill while the previous one drains. Both sides use a full valid/ready handshake with backpressure. Bits leave in interleaved order.

Parameters:
- NCBPS_BASE, 192, coded bits per block for QPSK; Ncbps = NCBPS_BASE*Ncpc/2.
- D, 16, interleaver column count d.
- NCBPS_MAX, 576, largest block size (64-QAM); sets bank depth.
- ADDR_W, $clog2(NCBPS_MAX), width of bit index.

Ports:
- clk  in  1  single clock, rising edge
- resetN  in  1  synchronous active-low reset
- mode  in  2  00 QPSK (Ncpc=2), 01 16-QAM (4), 10 64-QAM (6), 11 treated as QPSK; sampled only on the first bit of a block
- valid_fec  in  1  input bit valid
- data_in  in  1  input coded bit
- ready_interleaver  out  1  interleaver can accept a bit
- ready_mod  in  1  modulator accepts an output bit
- valid_interleaver  out  1  output bit valid
- data_out  out  1  interleaved bit
- data_out_index  out  ADDR_W  output position j, 0..Ncbps-1
- block_last  out  1  high with the final bit of a block
- block_mode  out  2  mode of the block currently draining

Behaviour:
- Reset is synchronous on resetN=0 at the clk edge. Reset clears both banks to EMPTY and sets wr_bank=0, rd_bank=0, k=0, rd_ptr=0. It also drives ready_interleaver=0, valid_interleaver=0, data_out=0, data_out_index=0, block_last=0 and block_mode=00. ready_interleaver rises in the first cycle after reset deasserts.
- Reset mid-operation discards all partial and full blocks, with no flush.
- Bank states are EMPTY, FILLING, FULL and DRAINING. Each bank holds NCBPS_MAX bits plus a latched mode.
- Write side:
  - ready_interleaver = 1 when bank[wr_bank] is EMPTY or FILLING.
  - An input handshake is valid_fec & ready_interleaver.
  - On the first handshake of a block (k=0), latch mode into the bank and set the bank to FILLING.
  - Each handshake writes data_in at address j(k), then k increments.
  - At k = Ncbps-1: set the bank to FULL, set k to 0 and toggle wr_bank.
- Permutation, computed with the latched mode (N = Ncbps, s = Ncpc/2):
  - m = (N/D)*(k mod D) + floor(k/D)
  - j = s*floor(m/s) + ((m + N - floor(D*m/N)) mod s)
  - Evaluate all intermediates at ADDR_W+5 bits; no truncation before the final mod.
- Read side:
  - Outputs are registered. valid_interleaver is high while bank[rd_bank] is FULL or DRAINING.
  - data_out = bank[rd_bank][rd_ptr] and data_out_index = rd_ptr.
  - An output handshake is valid_interleaver & ready_mod; it advances rd_ptr.
  - While ready_mod=0, data_out, data_out_index and block_last hold stable.
  - block_last = (rd_ptr == Ncbps-1). On its handshake: bank goes to EMPTY, rd_ptr goes to 0, rd_bank toggles.
- Latency: the first output bit of a block is valid 2 cycles after the handshake of input bit N-1, provided the read side is idle.
- Throughput: 1 bit/cycle on each side when both banks are in use.
- Simultaneous events:
  - A write completing a bank and a read freeing the other bank in the same cycle are both honoured.
  - If both banks are FULL/DRAINING, ready_interleaver=0 until the draining bank empties. ready_interleaver re-asserts in the cycle after that bank's last-bit handshake.
- A mode change during a block is ignored until the next k=0.

Decomposition:
- Package interleaver_pkg:
  - mode_t enum (MODE_QPSK, MODE_16QAM, MODE_64QAM)
  - bank_state_t enum
  - Functions ncpc_of(mode_t) and ncbps_of(mode_t)
  - Constant D
- Sub-module interleaver_perm: combinational k, mode -> j. It can be reused by the deinterleaver.
- Top level holds the banks, the FSMs and the handshakes.

Test Plan:
- QPSK, input bit k=1 only = 1 (all others 0), ready_mod=1 -> exactly one 1 out, at data_out_index=12. Input k=16 -> index 1. block_last at index 191.
- 16-QAM, single 1 at k=1 -> out at index 25. Single 1 at k=0 -> index 0. Block length 384.
- 64-QAM, single 1 at k=1 -> index 38. Block length 576. block_mode=10 throughout the drain.
- Back-to-back blocks with ready_mod=1 and valid_fec=1 continuous:
  - QPSK then 64-QAM, mode switched at the block boundary -> no input stall after the first block.
  - Each block is permuted with its own mode.
- Backpressure: ready_mod=0 for 400 cycles during a QPSK stream:
  - ready_interleaver drops after the second bank fills.
  - data_out and data_out_index hold stable.
  - On release, all 384 bits emerge in order with no loss.
- resetN=0 asserted mid-fill and mid-drain -> next cycle valid_interleaver=0 and ready_interleaver=0. After release, a fresh QPSK block interleaves correctly starting at k=0.
